// File: rtl/exu_longp_wbck_pkg.sv
// ----------------------------------------------------------------------------
// exu_longp_wbck_pkg
// Shared constants for the long-pipe writeback path.
//   LP_SRC_*            : fixed source slot assignments on the long-pipe bus
//   MYRISCV_DATADW      : architectural data width (REGBUS)
//   MYRISCV_REGADDRBUS  : register index width (REGADDRBUS)
//   wrap_idx()          : modulo-N index step used by the round-robin logic
// ----------------------------------------------------------------------------
package exu_longp_wbck_pkg;

    localparam int unsigned LP_SRC_CORDIC      = 0;
    localparam int unsigned LP_SRC_DIV         = 1;
    localparam int unsigned LP_SRC_NUM         = 4;

    localparam int unsigned MYRISCV_DATADW     = 64;
    localparam int unsigned MYRISCV_REGADDRBUS = 5;

    // (base + off) mod n, for walking a circular source list.
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/exu_longp_wbck_rr_arbiter.sv
// ----------------------------------------------------------------------------
// exu_longp_wbck_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and
// walks upward, wrapping modulo N; the first requester found wins. The
// pointer register itself lives in the parent.
// Ports:
//   req        in  N   request vector
//   ptr        in  PW  highest-priority slot for this cycle
//   en         in  1   when low, grant is forced to zero
//   grant      out N   one-hot grant (gated by en)
//   grant_idx  out PW  binary index of the winner (valid whenever any req set)
// ----------------------------------------------------------------------------
module exu_longp_wbck_rr_arbiter
    import exu_longp_wbck_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = PW'(wrap_idx(32'(ptr), off, N));
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (en && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/exu_longp_wbck.sv
// ----------------------------------------------------------------------------
// exu_longp_wbck
// Long-pipe writeback collector. Picks one of NUM_SRC multi-cycle result
// sources round-robin, parks the winner in a single hold entry, and merges
// it with the single-cycle ALU writeback (ALU has priority) onto one
// registered regfile write port. A starvation counter asks the ALU for a
// bubble when the hold entry has been blocked STARVE_MAX cycles in a row.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   src_vld/rdy    per-source result handshake
//   src_rdidx      packed destination indices, source i at [i*RIDX_W +: RIDX_W]
//   src_data       packed result data, source i at [i*XLEN +: XLEN]
//   alu_wb_*       ALU writeback, always accepted
//   alu_stall_o    request the ALU to withhold alu_wb_vld next cycle
//   rf_wen/waddr/wdata  registered regfile write port
//   lp_busy_o      any source valid or hold entry occupied
// ----------------------------------------------------------------------------
module exu_longp_wbck
    import exu_longp_wbck_pkg::*;
#(
    parameter int unsigned NUM_SRC    = LP_SRC_NUM,
    parameter int unsigned XLEN       = MYRISCV_DATADW,
    parameter int unsigned RIDX_W     = MYRISCV_REGADDRBUS,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_vld,
    output logic [NUM_SRC-1:0]        src_rdy,
    input  logic [NUM_SRC*RIDX_W-1:0] src_rdidx,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    input  logic                      alu_wb_vld,
    input  logic [RIDX_W-1:0]         alu_wb_rdidx,
    input  logic [XLEN-1:0]           alu_wb_data,
    output logic                      alu_stall_o,
    output logic                      rf_wen,
    output logic [RIDX_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic                      lp_busy_o
);

    localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic              hold_vld_q,   hold_vld_d;
    logic [RIDX_W-1:0] hold_idx_q,   hold_idx_d;
    logic [XLEN-1:0]   hold_data_q,  hold_data_d;
    logic [PW-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [CW-1:0]     starve_cnt_q, starve_cnt_d;

    logic              rf_wen_d;
    logic [RIDX_W-1:0] rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_d;

    logic              drain;
    logic              can_acc;
    logic              arb_en;
    logic              accept;
    logic [NUM_SRC-1:0] grant;
    logic [PW-1:0]     grant_idx;
    logic [RIDX_W-1:0] sel_idx;
    logic [XLEN-1:0]   sel_data;

    // Hold entry leaves whenever the ALU is not using the port; a fresh
    // result may be taken in that same cycle, so the entry never idles.
    assign drain   = hold_vld_q & ~alu_wb_vld;
    assign can_acc = ~hold_vld_q | drain;
    // Keep src_rdy low while reset is asserted so nothing is consumed
    // and then lost when the state clears.
    assign arb_en  = rst_n & can_acc;

    exu_longp_wbck_rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .req       (src_vld),
        .ptr       (rr_ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // grant only ever covers a requesting source, so it is the handshake.
    assign src_rdy = grant;
    assign accept  = |grant;

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_idx  = src_rdidx[i*RIDX_W +: RIDX_W];
                sel_data = src_data[i*XLEN +: XLEN];
            end
        end
    end

    // Hold entry and round-robin pointer.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_idx_d  = hold_idx_q;
        hold_data_d = hold_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_idx_d  = sel_idx;
            hold_data_d = sel_data;
            rr_ptr_d    = PW'(wrap_idx(32'(grant_idx), 1, NUM_SRC));
        end else if (drain) begin
            hold_vld_d  = 1'b0;
        end
    end

    // Regfile port: ALU first, then the hold entry. Index 0 still drains,
    // only the write enable is dropped.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        if (alu_wb_vld) begin
            rf_wen_d   = (alu_wb_rdidx != '0);
            rf_waddr_d = alu_wb_rdidx;
            rf_wdata_d = alu_wb_data;
        end else if (hold_vld_q) begin
            rf_wen_d   = (hold_idx_q != '0);
            rf_waddr_d = hold_idx_q;
            rf_wdata_d = hold_data_q;
        end
    end

    // Starvation: count consecutive cycles the hold entry loses to the ALU.
    always_comb begin
        starve_cnt_d = '0;
        if (hold_vld_q && alu_wb_vld) begin
            if (starve_cnt_q == CW'(STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q;
            end else begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld_q   <= 1'b0;
            hold_idx_q   <= '0;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
        end else begin
            hold_vld_q   <= hold_vld_d;
            hold_idx_q   <= hold_idx_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rf_wen       <= rf_wen_d;
            rf_waddr     <= rf_waddr_d;
            rf_wdata     <= rf_wdata_d;
        end
    end

    assign alu_stall_o = (starve_cnt_q == CW'(STARVE_MAX));
    assign lp_busy_o   = hold_vld_q | (|src_vld);

endmodule

// File: tb/tb_exu_longp_wbck.sv
// ----------------------------------------------------------------------------
// tb_exu_longp_wbck
// Directed self-checking bench for exu_longp_wbck. Inputs change 1ns after
// posedge; outputs are sampled 1-2ns after posedge.
// ----------------------------------------------------------------------------
module tb_exu_longp_wbck;

    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned XLEN       = 64;
    localparam int unsigned RIDX_W     = 5;
    localparam int unsigned STARVE_MAX = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        src_vld;
    logic [NUM_SRC-1:0]        src_rdy;
    logic [NUM_SRC*RIDX_W-1:0] src_rdidx;
    logic [NUM_SRC*XLEN-1:0]   src_data;
    logic                      alu_wb_vld;
    logic [RIDX_W-1:0]         alu_wb_rdidx;
    logic [XLEN-1:0]           alu_wb_data;
    logic                      alu_stall_o;
    logic                      rf_wen;
    logic [RIDX_W-1:0]         rf_waddr;
    logic [XLEN-1:0]           rf_wdata;
    logic                      lp_busy_o;

    int checks;
    int failures;

    exu_longp_wbck #(
        .NUM_SRC    (NUM_SRC),
        .XLEN       (XLEN),
        .RIDX_W     (RIDX_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_vld      (src_vld),
        .src_rdy      (src_rdy),
        .src_rdidx    (src_rdidx),
        .src_data     (src_data),
        .alu_wb_vld   (alu_wb_vld),
        .alu_wb_rdidx (alu_wb_rdidx),
        .alu_wb_data  (alu_wb_data),
        .alu_stall_o  (alu_stall_o),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .lp_busy_o    (lp_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_vld      = '0;
        src_rdidx    = '0;
        src_data     = '0;
        alu_wb_vld   = 1'b0;
        alu_wb_rdidx = '0;
        alu_wb_data  = '0;
    endtask

    task automatic set_src(input int i, input logic [RIDX_W-1:0] idx,
                           input logic [XLEN-1:0] d);
        src_vld[i]                   = 1'b1;
        src_rdidx[i*RIDX_W +: RIDX_W] = idx;
        src_data[i*XLEN +: XLEN]     = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        set_src(0, 5'd3, 64'h1);
        #1;
        checks++;
        if (src_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rdy_gate: got %b want 0000", src_rdy);
        end
        tick();
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_rf: got wen=%b addr=%0d data=%h want 0/0/0",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (alu_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b want 0", alu_stall_o);
        end
        checks++;
        if (lp_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy_src: got %b want 1", lp_busy_o);
        end
        idle_inputs();
        #1;
        checks++;
        if (lp_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_idle: got %b want 0", lp_busy_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        set_src(0, 5'd5, 64'h3F80_0000);
        #1;
        checks++;
        if (src_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL single_rdy: got %b want 0001", src_rdy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rf_wen !== 1'b0 || lp_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: got wen=%b busy=%b want 0/1", rf_wen, lp_busy_o);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h3F80_0000) begin
            failures++;
            $display("FAIL single_write: got wen=%b addr=%0d data=%h want 1/5/3f800000",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (lp_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_drop: got %b want 0", lp_busy_o);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd5) begin
            failures++;
            $display("FAIL single_idle: got wen=%b addr=%0d want 0/5", rf_wen, rf_waddr);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]        want_rdy;
        logic [RIDX_W-1:0] want_idx;
        logic [XLEN-1:0]   want_data;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_src(i, RIDX_W'(i + 1), 64'h100 + 64'(i));
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            want_rdy = 4'(1 << (k % 4));
            checks++;
            if (src_rdy !== want_rdy) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, src_rdy, want_rdy);
            end
            @(posedge clk);
            #1;
            if (k >= 1) begin
                want_idx  = RIDX_W'(((k - 1) % 4) + 1);
                want_data = 64'h100 + 64'((k - 1) % 4);
                checks++;
                if (rf_wen !== 1'b1 || rf_waddr !== want_idx || rf_wdata !== want_data) begin
                    failures++;
                    $display("FAIL rr_write[%0d]: got wen=%b addr=%0d data=%h want 1/%0d/%h",
                             k, rf_wen, rf_waddr, rf_wdata, want_idx, want_data);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic want_stall;
        apply_reset();
        set_src(0, 5'd7, 64'hAA);
        tick();
        idle_inputs();
        alu_wb_vld   = 1'b1;
        alu_wb_rdidx = 5'd8;
        alu_wb_data  = 64'h55;
        for (int j = 1; j <= 6; j++) begin
            #1;
            want_stall = (j >= 5);
            checks++;
            if (alu_stall_o !== want_stall) begin
                failures++;
                $display("FAIL starve_stall[%0d]: got %b want %b", j, alu_stall_o, want_stall);
            end
            tick();
            checks++;
            if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 64'h55) begin
                failures++;
                $display("FAIL starve_alu_wins[%0d]: got wen=%b addr=%0d data=%h want 1/8/55",
                         j, rf_wen, rf_waddr, rf_wdata);
            end
        end
        alu_wb_vld = 1'b0;
        #1;
        checks++;
        if (alu_stall_o !== 1'b1 || src_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL starve_saturated: got stall=%b want 1", alu_stall_o);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'hAA) begin
            failures++;
            $display("FAIL starve_drain: got wen=%b addr=%0d data=%h want 1/7/aa",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (alu_stall_o !== 1'b0 || lp_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL starve_clear: got stall=%b busy=%b want 0/0", alu_stall_o, lp_busy_o);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        set_src(0, 5'd0, 64'hFFFF);
        #1;
        checks++;
        if (src_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL x0_rdy: got %b want 0001", src_rdy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (lp_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL x0_hold: got busy=%b want 1", lp_busy_o);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_wdata !== 64'hFFFF || lp_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_suppress: got wen=%b data=%h busy=%b want 0/ffff/0",
                     rf_wen, rf_wdata, lp_busy_o);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_src(0, 5'd3, 64'h33);
        tick();
        idle_inputs();
        set_src(1, 5'd9, 64'h99);
        #1;
        checks++;
        if (src_rdy !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_rdy_in_drain: got %b want 0010", src_rdy);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'h33) begin
            failures++;
            $display("FAIL b2b_first: got wen=%b addr=%0d data=%h want 1/3/33",
                     rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99) begin
            failures++;
            $display("FAIL b2b_second: got wen=%b addr=%0d data=%h want 1/9/99",
                     rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        set_src(0, 5'd4, 64'h44);
        tick();
        // Pointer is now 1 and the hold entry is blocked by the ALU.
        alu_wb_vld   = 1'b1;
        alu_wb_rdidx = 5'd1;
        alu_wb_data  = 64'h11;
        set_src(0, 5'd6, 64'h66);
        set_src(2, 5'd12, 64'hC0DE);
        #1;
        checks++;
        if (src_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL mid_blocked: got %b want 0000", src_rdy);
        end
        rst_n      = 1'b0;
        alu_wb_vld = 1'b0;
        #1;
        checks++;
        if (src_rdy !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rdy_in_reset: got %b want 0000", src_rdy);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || src_rdy !== 4'b0000 || alu_stall_o !== 1'b0)
        begin
            failures++;
            $display("FAIL mid_cleared: got wen=%b addr=%0d rdy=%b stall=%b want 0/0/0000/0",
                     rf_wen, rf_waddr, src_rdy, alu_stall_o);
        end
        rst_n = 1'b1;
        #1;
        // Pointer back at 0, so source 0 beats source 2.
        checks++;
        if (src_rdy !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr_reset: got %b want 0001", src_rdy);
        end
        tick();
        src_vld[0] = 1'b0;
        #1;
        checks++;
        if (src_rdy !== 4'b0100) begin
            failures++;
            $display("FAIL mid_src2_rdy: got %b want 0100", src_rdy);
        end
        tick();
        idle_inputs();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 64'h66) begin
            failures++;
            $display("FAIL mid_write_src0: got wen=%b addr=%0d data=%h want 1/6/66",
                     rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 64'hC0DE) begin
            failures++;
            $display("FAIL mid_write_src2: got wen=%b addr=%0d data=%h want 1/12/c0de",
                     rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_starvation();
        test_x0();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
